// File: rtl/pipe_pkg.sv
// Shared types and default geometry for the memory-access stage.
package pipe_pkg;

  localparam int DEF_REGI_BITS  = 4;
  localparam int DEF_VECT_BITS  = 2;
  localparam int DEF_MEMO_LINES = 64;
  localparam int DEF_VECT_SIZE  = 8;
  localparam int DEF_ELEM_SIZE  = 8;
  localparam int DATA_W = DEF_ELEM_SIZE * DEF_VECT_SIZE;
  localparam int ADDR_W = $clog2(DEF_MEMO_LINES);

  typedef enum logic {IDLE, ACCESS} mem_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]        data;
    logic [DEF_REGI_BITS-1:0] intDest;
    logic [DEF_VECT_BITS-1:0] vecDest;
    logic                     weInt;
    logic                     weVec;
  } wb_word_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait counter for an outstanding memory request; expired_o flags the cycle
// whose increment would reach TIMEOUT_CYC.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic [$clog2(TIMEOUT_CYC+1)-1:0] count_o,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC+1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       count_o <= '0;
    else if (clear_i)  count_o <= '0;
    else if (enable_i) count_o <= count_o + 1'b1;
  end

  assign expired_o = enable_i && (count_o == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM consumer: optional single load/store over req/ack with a bounded
// wait, producing a registered writeback word plus jump/end events.
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int REGI_BITS   = DEF_REGI_BITS,
  parameter int VECT_BITS   = DEF_VECT_BITS,
  parameter int MEMO_LINES  = DEF_MEMO_LINES,
  parameter int VECT_SIZE   = DEF_VECT_SIZE,
  parameter int ELEM_SIZE   = DEF_ELEM_SIZE,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            valid_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0]  data_i,
  input  logic                            flagMemRead_i,
  input  logic                            flagMemWrite_i,
  input  logic                            flagEnd_i,
  input  logic                            flagNop_i,
  input  logic                            enableJump_i,
  input  logic [9:0]                      jumpAddress_i,
  input  logic [REGI_BITS-1:0]            intRegDest_i,
  input  logic                            writeResultInt_i,
  input  logic [VECT_BITS-1:0]            vecRegDest_i,
  input  logic                            writeResultV_i,
  output logic                            stall_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [$clog2(MEMO_LINES)-1:0]   mem_addr_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0]  mem_wdata_o,
  input  logic                            mem_ack_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0]  mem_rdata_i,
  output logic                            wb_valid_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0]  wb_data_o,
  output logic [REGI_BITS-1:0]            wb_int_dest_o,
  output logic [VECT_BITS-1:0]            wb_vec_dest_o,
  output logic                            wb_we_int_o,
  output logic                            wb_we_vec_o,
  output logic                            jump_en_o,
  output logic [9:0]                      jump_addr_o,
  output logic                            halted_o,
  output logic                            err_o
);

  localparam int AW = $clog2(MEMO_LINES);

  mem_state_t state, nextState;

  // Pipe word captured at accept; upstream is free to advance on that edge.
  wb_word_t   hold;
  logic       holdRead, holdJump, holdEnd;
  logic [9:0] holdJumpAddr;

  wb_word_t   retWord;
  logic       retJump, retEnd;
  logic [9:0] retJumpAddr;

  logic accept, isMem, ackHit, toHit, retire, expired, ctrClear, ctrEn;
  logic [$clog2(TIMEOUT_CYC+1)-1:0] waitCount;

  assign accept = (state == IDLE) && valid_i && !flagNop_i && !halted_o;
  assign isMem  = flagMemRead_i || flagMemWrite_i;
  assign ctrEn  = (state == ACCESS) && !mem_ack_i;
  assign ackHit = (state == ACCESS) && mem_ack_i;
  assign toHit  = expired;
  assign retire = (accept && !isMem) || ackHit || toHit;
  assign ctrClear = (state == IDLE) || ackHit || toHit;
  assign stall_o  = (state == ACCESS);

  mem_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) uCtr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (ctrClear),
    .enable_i (ctrEn),
    .count_o  (waitCount),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && isMem)  nextState = ACCESS;
      ACCESS:  if (ackHit || toHit)  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    retWord     = '0;
    retJump     = 1'b0;
    retEnd      = 1'b0;
    retJumpAddr = '0;
    if (state == IDLE) begin
      retWord.data    = data_i;
      retWord.intDest = intRegDest_i;
      retWord.vecDest = vecRegDest_i;
      retWord.weInt   = writeResultInt_i;
      retWord.weVec   = writeResultV_i;
      retJump         = enableJump_i;
      retEnd          = flagEnd_i;
      retJumpAddr     = jumpAddress_i;
    end else begin
      // Stores and timeouts never write a register; timeouts return zero data.
      retWord.intDest = hold.intDest;
      retWord.vecDest = hold.vecDest;
      retJump         = holdJump;
      retEnd          = holdEnd;
      retJumpAddr     = holdJumpAddr;
      if (ackHit) begin
        retWord.data  = holdRead ? mem_rdata_i : hold.data;
        retWord.weInt = holdRead && hold.weInt;
        retWord.weVec = holdRead && hold.weVec;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold         <= '0;
      holdRead     <= 1'b0;
      holdJump     <= 1'b0;
      holdEnd      <= 1'b0;
      holdJumpAddr <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else if (accept && isMem) begin
      hold.data    <= data_i;
      hold.intDest <= intRegDest_i;
      hold.vecDest <= vecRegDest_i;
      hold.weInt   <= writeResultInt_i;
      hold.weVec   <= writeResultV_i;
      holdRead     <= !flagMemWrite_i;
      holdJump     <= enableJump_i;
      holdEnd      <= flagEnd_i;
      holdJumpAddr <= jumpAddress_i;
      mem_req_o    <= 1'b1;
      mem_we_o     <= flagMemWrite_i;
      mem_addr_o   <= jumpAddress_i[AW-1:0];
      mem_wdata_o  <= data_i;
    end else if (ackHit || toHit) begin
      mem_req_o    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o    <= 1'b0;
      wb_data_o     <= '0;
      wb_int_dest_o <= '0;
      wb_vec_dest_o <= '0;
      wb_we_int_o   <= 1'b0;
      wb_we_vec_o   <= 1'b0;
      jump_en_o     <= 1'b0;
      jump_addr_o   <= '0;
      halted_o      <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      wb_valid_o <= retire;
      jump_en_o  <= retire && retJump;
      if (retire) begin
        wb_data_o     <= retWord.data;
        wb_int_dest_o <= retWord.intDest;
        wb_vec_dest_o <= retWord.vecDest;
        wb_we_int_o   <= retWord.weInt;
        wb_we_vec_o   <= retWord.weVec;
        jump_addr_o   <= retJumpAddr;
      end
      if (retire && retEnd) halted_o <= 1'b1;
      if (toHit || (accept && flagMemRead_i && flagMemWrite_i)) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short timeout.
module tb_mem_access_stage;

  logic        clk, rst_n;
  logic        valid, rd, wr, endF, nop, jmp, wrInt, wrV, ack;
  logic [63:0] data, rdata;
  logic [9:0]  jaddr;
  logic [3:0]  intDest;
  logic [1:0]  vecDest;

  logic        stall, req, we, wbValid, wbWeInt, wbWeVec, jumpEn, halted, err;
  logic [5:0]  addr;
  logic [63:0] wdata, wbData;
  logic [3:0]  wbIntDest;
  logic [1:0]  wbVecDest;
  logic [9:0]  jumpAddr;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT_CYC(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data),
    .flagMemRead_i(rd), .flagMemWrite_i(wr), .flagEnd_i(endF), .flagNop_i(nop),
    .enableJump_i(jmp), .jumpAddress_i(jaddr),
    .intRegDest_i(intDest), .writeResultInt_i(wrInt),
    .vecRegDest_i(vecDest), .writeResultV_i(wrV),
    .stall_o(stall), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr),
    .mem_wdata_o(wdata), .mem_ack_i(ack), .mem_rdata_i(rdata),
    .wb_valid_o(wbValid), .wb_data_o(wbData), .wb_int_dest_o(wbIntDest),
    .wb_vec_dest_o(wbVecDest), .wb_we_int_o(wbWeInt), .wb_we_vec_o(wbWeVec),
    .jump_en_o(jumpEn), .jump_addr_o(jumpAddr), .halted_o(halted), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idleIn();
    valid = 0; rd = 0; wr = 0; endF = 0; nop = 0; jmp = 0; wrInt = 0; wrV = 0;
    data = '0; jaddr = '0; intDest = '0; vecDest = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; ack = 0; rdata = '0;
    idleIn();
    #12;
    chk("rst_wb_valid", wbValid, 0);
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_jump_addr", jumpAddr, 0);
    rst_n = 1;

    // ALU passthrough
    valid = 1; data = 64'hA5; intDest = 3; wrInt = 1;
    tick();
    chk("alu_wb_valid", wbValid, 1);
    chk("alu_wb_data", wbData, 64'hA5);
    chk("alu_int_dest", wbIntDest, 3);
    chk("alu_we_int", wbWeInt, 1);
    chk("alu_stall", stall, 0);
    chk("alu_req", req, 0);
    idleIn();
    tick();
    chk("alu_pulse_end", wbValid, 0);

    // Ack while idle has no effect
    ack = 1; rdata = 64'hDEAD;
    tick();
    ack = 0;
    chk("idle_ack_wb", wbValid, 0);
    chk("idle_ack_req", req, 0);

    // Load, ack in third access cycle
    valid = 1; rd = 1; jaddr = 10'd5; intDest = 7; wrInt = 1;
    tick();
    idleIn();
    chk("ld_req", req, 1);
    chk("ld_we", we, 0);
    chk("ld_addr", addr, 5);
    chk("ld_stall1", stall, 1);
    chk("ld_wb_none", wbValid, 0);
    tick();
    chk("ld_stall2", stall, 1);
    tick();
    chk("ld_stall3", stall, 1);
    ack = 1; rdata = 64'h1122;
    tick();
    ack = 0;
    chk("ld_wb_valid", wbValid, 1);
    chk("ld_wb_data", wbData, 64'h1122);
    chk("ld_int_dest", wbIntDest, 7);
    chk("ld_we_int", wbWeInt, 1);
    chk("ld_req_drop", req, 0);
    chk("ld_stall_drop", stall, 0);

    // Store to last line, ack next cycle
    valid = 1; wr = 1; jaddr = 10'd63; data = 64'hFF; wrInt = 1; wrV = 1;
    tick();
    idleIn();
    chk("st_req", req, 1);
    chk("st_we", we, 1);
    chk("st_addr", addr, 63);
    chk("st_wdata", wdata, 64'hFF);
    ack = 1;
    tick();
    ack = 0;
    chk("st_wb_valid", wbValid, 1);
    chk("st_wb_data", wbData, 64'hFF);
    chk("st_we_int", wbWeInt, 0);
    chk("st_we_vec", wbWeVec, 0);
    chk("st_err", err, 0);

    // Jump pulse, then jump on a nop word ignored
    valid = 1; jmp = 1; jaddr = 10'h2AB;
    tick();
    chk("jmp_en", jumpEn, 1);
    chk("jmp_addr", jumpAddr, 10'h2AB);
    nop = 1; jaddr = 10'h111;
    tick();
    idleIn();
    chk("nop_wb", wbValid, 0);
    chk("nop_jmp", jumpEn, 0);

    // Timeout: load with no ack, limit 4
    valid = 1; rd = 1; jaddr = 10'd9; wrInt = 1; intDest = 2;
    tick();
    idleIn();
    chk("to_req1", req, 1);
    tick(); tick(); tick();
    chk("to_req4", req, 1);
    chk("to_no_err_yet", err, 0);
    tick();
    chk("to_req_drop", req, 0);
    chk("to_wb_valid", wbValid, 1);
    chk("to_wb_data", wbData, 0);
    chk("to_we_int", wbWeInt, 0);
    chk("to_err", err, 1);
    tick();
    chk("to_err_sticky", err, 1);

    // End word halts; later words ignored
    valid = 1; endF = 1; data = 64'h77;
    tick();
    chk("end_wb_valid", wbValid, 1);
    chk("end_halted", halted, 1);
    endF = 0;
    for (int i = 1; i <= 3; i++) begin
      data = 64'(i);
      tick();
      chk("halt_wb", wbValid, 0);
      chk("halt_stall", stall, 0);
    end
    idleIn();
    rst_n = 0; #2;
    chk("halt_cleared", halted, 0);
    chk("err_cleared", err, 0);
    rst_n = 1;

    // Reset during an outstanding load
    valid = 1; rd = 1; jaddr = 10'd4;
    tick();
    idleIn();
    chk("rl_req", req, 1);
    tick();
    #2 rst_n = 0; #1;
    chk("rl_req_async", req, 0);
    chk("rl_stall_async", stall, 0);
    #2 rst_n = 1;
    tick();
    chk("rl_no_wb1", wbValid, 0);
    tick();
    chk("rl_no_wb2", wbValid, 0);

    // Read and write together: treated as a store, error flagged
    valid = 1; rd = 1; wr = 1; jaddr = 10'd12; data = 64'h3C; wrInt = 1;
    tick();
    idleIn();
    chk("rw_we", we, 1);
    chk("rw_err", err, 1);
    ack = 1; rdata = 64'h99;
    tick();
    ack = 0;
    chk("rw_wb_data", wbData, 64'h3C);
    chk("rw_we_int", wbWeInt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
